ldpc_encoder: RTL and testbench

LDPC_ENCODER -- requirements
Module: ldpc_encoder

---
 rtl/ldpc_encoder.sv | 178 +++++++++++++++++
 tb/tb_ldpc_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_encoder.sv
// ---------------------------------------------------------------------------
// ldpc_encoder -- serial-in, parallel-out systematic LDPC encoder.
//
// Message bits arrive one per accepted handshake, index 0 first. Each
// accepted '1' XORs the matching row of the generator p_mat into an N_C-bit
// GF(2) parity accumulator. After the K-th bit the codeword
// {message, parity} is presented on `codeword` until the consumer accepts it.
//
// Optional feature macro: ENC_LLR_OUT_EN
//   When defined, adds the `llr_out` port. Each entry is the ideal channel
//   LLR for its codeword bit: +LLR_MAG for 0 and -LLR_MAG for 1. It is
//   registered together with `codeword`.
//   When undefined, the port and its logic are absent.
//
// Parameters
//   N_V      codeword length in bits
//   N_C      parity bits per codeword
//   K        message bits per codeword, must equal N_V-N_C
//   LLR_MAG  channel-LLR magnitude, used only with ENC_LLR_OUT_EN
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   p_mat      [0:K-1][0:N_C-1] parity generator, static during a frame
//   in_valid   in_bit is valid
//   in_ready   encoder can accept a message bit (S_LOAD)
//   in_bit     serial message bit
//   out_valid  codeword is valid (S_OUT)
//   out_ready  consumer accepts the codeword
//   codeword   [0:N_V-1]: message in [0:K-1], parity in [K:N_V-1]
//   llr_out    per-bit channel LLR (ENC_LLR_OUT_EN only)
// ---------------------------------------------------------------------------
module ldpc_encoder #(
  parameter int                 N_V     = 44,
  parameter int                 N_C     = 12,
  parameter int                 K       = N_V - N_C,
  parameter logic signed [7:0]  LLR_MAG = 8'sd64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:K-1][0:N_C-1]     p_mat,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_bit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [0:N_V-1]            codeword
`ifdef ENC_LLR_OUT_EN
  ,
  output logic signed [7:0]         llr_out [0:N_V-1]
`endif
);

  // bit_cnt indexes 0..K-1; keep at least one bit for degenerate K.
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  // Elaboration-time sanity checks on the configuration.
  if (K != N_V - N_C) begin : g_bad_k
    $error("ldpc_encoder: K must equal N_V-N_C");
  end
  if (LLR_MAG <= 8'sd0) begin : g_bad_llr
    $error("ldpc_encoder: LLR_MAG must be positive");
  end

  typedef enum logic {
    S_LOAD = 1'b0,
    S_OUT  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [0:N_C-1]     parity_q, parity_d;
  logic [0:N_V-1]     codeword_q, codeword_d;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    parity_d   = parity_q;
    codeword_d = codeword_q;
    in_ready   = (state_q == S_LOAD);
    out_valid  = (state_q == S_OUT);

    unique case (state_q)
      S_LOAD: begin
        // in_ready is 1 here, so in_valid alone completes the handshake.
        if (in_valid) begin
          // Compare-based selection instead of a variable index keeps the
          // index width independent of N_V and K.
          for (int i = 0; i < K; i++) begin
            if (CNT_W'(i) == bit_cnt_q) begin
              codeword_d[i] = in_bit;
              if (in_bit) begin
                parity_d = parity_q ^ p_mat[i];
              end
            end
          end

          if (bit_cnt_q == CNT_W'(K - 1)) begin
            // Final parity already includes the last bit's row.
            codeword_d[K:N_V-1] = parity_d;
            bit_cnt_d           = '0;
            state_d             = S_OUT;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      S_OUT: begin
        // in_bit/in_valid are ignored; codeword holds until accepted.
        if (out_ready) begin
          parity_d = '0;
          state_d  = S_LOAD;
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: codeword is a plain flop bank, not a RAM, so it can be cleared
    // on reset; that gives a defined all-zero output right after rst.
    if (rst) begin
      state_q    <= S_LOAD;
      bit_cnt_q  <= '0;
      parity_q   <= '0;
      codeword_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      parity_q   <= parity_d;
      codeword_q <= codeword_d;
    end
  end

  assign codeword = codeword_q;

`ifdef ENC_LLR_OUT_EN
  // -------------------------------------------------------------------------
  // Channel LLR mapping, registered alongside codeword so both change on the
  // same edge and both hold while a codeword waits for out_ready.
  // -------------------------------------------------------------------------
  logic signed [7:0] llr_q [0:N_V-1];
  logic signed [7:0] llr_d [0:N_V-1];

  always_comb begin
    for (int i = 0; i < N_V; i++) begin
      llr_d[i] = codeword_d[i] ? -LLR_MAG : LLR_MAG;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_V; i++) begin
      if (rst) begin
        llr_q[i] <= '0;
      end else begin
        llr_q[i] <= llr_d[i];
      end
    end
  end

  assign llr_out = llr_q;
`endif

endmodule

// File: tb/tb_ldpc_encoder.sv
// ---------------------------------------------------------------------------
// tb_ldpc_encoder -- self-checking bench for ldpc_encoder (default params).
// Expected codewords come from a matrix-vector product over GF(2) computed
// directly from the message and generator arrays.
// ---------------------------------------------------------------------------
module tb_ldpc_encoder;

  localparam int N_V = 44;
  localparam int N_C = 12;
  localparam int K   = N_V - N_C;

  logic                  clk;
  logic                  rst;
  logic [0:K-1][0:N_C-1] pm;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_bit;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:N_V-1]        codeword;
`ifdef ENC_LLR_OUT_EN
  logic signed [7:0]     llr_out [0:N_V-1];
`endif

  int errors = 0;
  int checks = 0;

  ldpc_encoder #(.N_V(N_V), .N_C(N_C)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_mat     (pm),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeword  (codeword)
`ifdef ENC_LLR_OUT_EN
    ,
    .llr_out   (llr_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // parity[j] = XOR over i of msg[i] AND G[i][j]
  function automatic logic [0:N_C-1] ref_parity(input logic [0:K-1] m,
                                                input logic [0:K-1][0:N_C-1] g);
    logic [0:N_C-1] p;
    p = '0;
    for (int j = 0; j < N_C; j++) begin
      for (int i = 0; i < K; i++) begin
        p[j] = p[j] ^ (m[i] & g[i][j]);
      end
    end
    return p;
  endfunction

  task automatic random_pm();
    for (int i = 0; i < K; i++) pm[i] = N_C'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one message; counts clock edges until K bits were accepted.
  task automatic send_frame(input logic [0:K-1] m, input bit gaps, output int cycles);
    int   idx;
    bit   v;
    logic rdy;
    idx    = 0;
    cycles = 0;
    while (idx < K && cycles < 1000) begin
      v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_bit   = v ? m[idx] : 1'($urandom);
      rdy      = in_ready;
      if (idx == K - 1 && v && rdy) check("out_valid_low_in_frame", 64'(out_valid), 64'd0);
      tick();
      cycles++;
      if (v && rdy) idx++;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    check("bits_accepted", 64'(idx), 64'(K));
  endtask

  task automatic check_output(input string tag, input logic [0:K-1] m);
    logic [0:N_C-1] p;
    p = ref_parity(m, pm);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_message"}, 64'(codeword[0:K-1]), 64'(m));
    check({tag, "_parity"}, 64'(codeword[K:N_V-1]), 64'(p));
`ifdef ENC_LLR_OUT_EN
    for (int i = 0; i < N_V; i++) begin
      logic e;
      e = (i < K) ? m[i] : p[i - K];
      check({tag, "_llr"}, 64'(llr_out[i]), e ? 64'(-64'sd64) : 64'sd64);
    end
`endif
  endtask

  // Accept the codeword; in_valid/in_bit high here must not be taken.
  task automatic handoff(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    check({tag, "_handoff_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_handoff_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [0:K-1]   msg;
    logic [0:N_C-1] xr;
    logic [0:N_V-1] exp_cw;
    int             cyc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    pm        = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_codeword", 64'(codeword), 64'd0);

    // All-zero message, in_valid held high: out_valid after 32 edges.
    random_pm();
    msg = '0;
    send_frame(msg, 1'b0, cyc);
    check("zero_latency_edges", 64'(cyc), 64'(K));
    check("zero_codeword", 64'(codeword), 64'd0);
    check_output("zero", msg);
    handoff("zero");

    // Single message bit 0 selects row 0 exactly.
    random_pm();
    pm[0] = 12'b1010_0000_0001;
    msg    = '0;
    msg[0] = 1'b1;
    send_frame(msg, 1'b0, cyc);
    check("row0_bit0", 64'(codeword[0]), 64'd1);
    check("row0_parity", 64'(codeword[K:N_V-1]), 64'hA01);
    check_output("row0", msg);
    handoff("row0");

    // All-ones message: parity is the XOR of every row.
    for (int t = 0; t < 3; t++) begin
      random_pm();
      msg = '1;
      xr  = '0;
      for (int i = 0; i < K; i++) xr = xr ^ pm[i];
      send_frame(msg, 1'b0, cyc);
      check("ones_row_xor", 64'(codeword[K:N_V-1]), 64'(xr));
      check_output("ones", msg);
      handoff("ones");
    end

    // Backpressure: codeword holds for 5 cycles while inputs wiggle.
    random_pm();
    msg = K'($urandom);
    send_frame(msg, 1'b1, cyc);
    exp_cw = {msg, ref_parity(msg, pm)};
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'($urandom);
      in_bit   = 1'($urandom);
      tick();
      check("hold_codeword", 64'(codeword), 64'(exp_cw));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    check_output("hold", msg);
    handoff("hold");

    // Random messages with random in_valid gaps.
    for (int t = 0; t < 4; t++) begin
      random_pm();
      msg = K'($urandom);
      send_frame(msg, 1'b1, cyc);
      check_output("rand", msg);
      handoff("rand");
    end

    // Reset mid-frame after 10 accepted ones, with handshakes active.
    random_pm();
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (10) tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_codeword", 64'(codeword), 64'd0);
    msg = '0;
    send_frame(msg, 1'b0, cyc);
    check("midrst_latency_edges", 64'(cyc), 64'(K));
    check("midrst_zero_parity", 64'(codeword[K:N_V-1]), 64'd0);
    check_output("midrst", msg);
    handoff("midrst");

    // Reset while a codeword is pending discards it.
    random_pm();
    msg = K'($urandom);
    send_frame(msg, 1'b1, cyc);
    check_output("outrst_pre", msg);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("outrst_out_valid", 64'(out_valid), 64'd0);
    check("outrst_in_ready", 64'(in_ready), 64'd1);
    msg = K'($urandom);
    send_frame(msg, 1'b1, cyc);
    check_output("outrst_post", msg);
    handoff("outrst_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
